samp_phase_gen: RTL and testbench

Parametrised multi-channel sampling clock generator for the time-interleaved SAR ADC front end.
- Produces a complementary pair per channel: samp for track and samp_b for hold.
- Inserts a programmable non-overlap gap between the two edges of each pair.
- Services enabled channels round-robin, one slot each, in single-shot or continuous mode, under a start/stop handshake.
- Sits between the ADC sequencer and the per-channel sampling switches; its registered outputs feed the analog drivers directly.

---
 rtl/samp_pkg.sv | 47 ++++
 rtl/samp_slot_timer.sv | 60 ++++++
 rtl/samp_phase_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_samp_phase_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/samp_pkg.sv
// Shared types and helpers for the sampling phase generator.
//   state_t    : run-control FSM states (IDLE, RUN, FINISH)
//   phase_t    : per-slot phase of the channel owning the slot
//   calc_w_eff : effective samp high time, at least one cycle
//   calc_p_eff : effective slot length, long enough for gap+track+gap
// The helpers work on 32-bit values; callers narrow the result to their
// own counter width, which is wide enough that nothing wraps.
package samp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NOV_PRE  = 2'd0,
    TRACK    = 2'd1,
    NOV_POST = 2'd2,
    HOLD     = 2'd3
  } phase_t;

  function automatic logic [31:0] calc_w_eff(input logic [31:0] width);
    logic [31:0] w;
    if (width == 32'd0) begin
      w = 32'd1;
    end else begin
      w = width;
    end
    return w;
  endfunction

  function automatic logic [31:0] calc_p_eff(input logic [31:0] period,
                                             input logic [31:0] width,
                                             input logic [31:0] gap);
    logic [31:0] min_p;
    logic [31:0] p;
    min_p = calc_w_eff(width) + (32'd2 * gap);
    if (period > min_p) begin
      p = period;
    end else begin
      p = min_p;
    end
    return p;
  endfunction

endpackage

// File: rtl/samp_slot_timer.sv
// Slot counter and phase decode shared by all channels.
//   clk_in, rst : clock and synchronous active-high reset
//   run         : counter advances while high, held at zero otherwise
//   gap_eff     : non-overlap cycles
//   w_eff       : effective track cycles
//   p_eff       : effective slot length
//   slot_end    : current cycle is the last one of the slot
//   phase_nxt   : phase belonging to the count value of the NEXT cycle, so
//                 that a register on it shows the phase in step with the count
module samp_slot_timer
  import samp_pkg::*;
#(
  parameter int EFF_W = 10
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic [EFF_W-1:0] gap_eff,
  input  logic [EFF_W-1:0] w_eff,
  input  logic [EFF_W-1:0] p_eff,
  output logic             slot_end,
  output phase_t           phase_nxt
);

  logic [EFF_W-1:0] cnt_q;
  logic [EFF_W-1:0] cnt_d;

  // next count, slot-end strobe and phase of the next count
  always_comb begin
    slot_end  = run && (cnt_q == (p_eff - {{(EFF_W-1){1'b0}}, 1'b1}));
    cnt_d     = {EFF_W{1'b0}};
    phase_nxt = HOLD;
    if (!run) begin
      cnt_d = {EFF_W{1'b0}};
    end else if (slot_end) begin
      cnt_d = {EFF_W{1'b0}};
    end else begin
      cnt_d = cnt_q + {{(EFF_W-1){1'b0}}, 1'b1};
    end
    if (cnt_d < gap_eff) begin
      phase_nxt = NOV_PRE;
    end else if (cnt_d < (gap_eff + w_eff)) begin
      phase_nxt = TRACK;
    end else if (cnt_d < (gap_eff + gap_eff + w_eff)) begin
      phase_nxt = NOV_POST;
    end else begin
      phase_nxt = HOLD;
    end
  end

  // slot counter register
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= {EFF_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/samp_phase_gen.sv
// Multi-channel sampling clock generator for a time-interleaved SAR ADC.
// Enabled channels are served round-robin, one slot each; the owner of a
// slot gets a non-overlapping track (samp) / hold (samp_b) pair.
//   clk_in, rst : clock and synchronous active-high reset
//   start, stop : run handshake (start ignored while busy or in FINISH)
//   mode        : 0 continuous, 1 single-shot
//   period, width, gap, ch_en : run configuration, latched at start
//   samp, samp_b: registered track/hold clocks per channel
//   ch_idx      : slot owner; busy : run in progress; done : end pulse
module samp_phase_gen
  import samp_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 2,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] width,
  input  logic [GAP_W-1:0] gap,
  input  logic [NCH-1:0]   ch_en,
  output logic [NCH-1:0]   samp,
  output logic [NCH-1:0]   samp_b,
  output logic [CH_W-1:0]  ch_idx,
  output logic             busy,
  output logic             done
);

  localparam int EFF_W = CNT_W + 2;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [NCH-1:0]   ch_en_q, ch_en_d;
  logic             stop_pend_q, stop_pend_d;
  logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
  logic [NCH-1:0]   samp_q, samp_d;
  logic [NCH-1:0]   samp_b_q, samp_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             start_ok_s;
  logic             run_s;
  logic             last_slot_s;
  logic             slot_end_s;
  phase_t           phase_nxt_s;
  logic [EFF_W-1:0] gap_eff_s, w_eff_s, p_eff_s;
  logic [NCH-1:0]   one_s;

  // First enabled channel after cur in ascending order, wrapping.
  function automatic logic [CH_W-1:0] next_en(input logic [CH_W-1:0] cur,
                                              input logic [NCH-1:0]  en);
    logic [CH_W-1:0] res;
    logic            found;
    int              idx;
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      idx = (int'(cur) + k) % NCH;
      if (!found && en[idx]) begin
        res   = CH_W'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  // True when no enabled channel sits above cur.
  function automatic logic none_above(input logic [CH_W-1:0] cur,
                                      input logic [NCH-1:0]  en);
    logic r;
    r = 1'b1;
    for (int j = 0; j < NCH; j++) begin
      if ((j > int'(cur)) && en[j]) begin
        r = 1'b0;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // FINISH counts as busy, so only IDLE can accept a start; stop wins a tie.
  assign start_ok_s  = (state_q == IDLE) && start && !stop;
  assign run_s       = (state_q == RUN);
  // A stop seen on the slot's last cycle still ends the run at that edge.
  assign last_slot_s = mode_q ? none_above(ch_idx_q, ch_en_q) : (stop_pend_q | stop);

  // Timing is derived from the configuration that will be in force next
  // cycle, so the very first slot phase is right on the start edge.
  assign w_eff_s   = EFF_W'(calc_w_eff(32'(width_d)));
  assign p_eff_s   = EFF_W'(calc_p_eff(32'(period_d), 32'(width_d), 32'(gap_d)));
  assign gap_eff_s = EFF_W'(gap_d);

  samp_slot_timer #(
    .EFF_W(EFF_W)
  ) u_timer (
    .clk_in   (clk_in),
    .rst      (rst),
    .run      (run_s),
    .gap_eff  (gap_eff_s),
    .w_eff    (w_eff_s),
    .p_eff    (p_eff_s),
    .slot_end (slot_end_s),
    .phase_nxt(phase_nxt_s)
  );

  // run-control next state, configuration latch and slot owner
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    period_d    = period_q;
    width_d     = width_q;
    gap_d       = gap_q;
    ch_en_d     = ch_en_q;
    stop_pend_d = stop_pend_q;
    ch_idx_d    = ch_idx_q;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          mode_d      = mode;
          period_d    = period;
          width_d     = width;
          gap_d       = gap;
          ch_en_d     = ch_en;
          stop_pend_d = 1'b0;
          if (ch_en == {NCH{1'b0}}) begin
            state_d  = FINISH;
            ch_idx_d = {CH_W{1'b0}};
          end else begin
            state_d  = RUN;
            ch_idx_d = next_en(CH_W'(NCH - 1), ch_en);
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        stop_pend_d = stop_pend_q | stop;
        if (slot_end_s) begin
          if (last_slot_s) begin
            state_d  = FINISH;
            ch_idx_d = {CH_W{1'b0}};
          end else begin
            state_d  = RUN;
            ch_idx_d = next_en(ch_idx_q, ch_en_q);
          end
        end else begin
          state_d = RUN;
        end
      end
      FINISH: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
        ch_idx_d    = {CH_W{1'b0}};
      end
      default: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
        ch_idx_d    = {CH_W{1'b0}};
      end
    endcase
  end

  // per-channel output fan-out for the coming cycle
  always_comb begin
    one_s           = {NCH{1'b0}};
    one_s[ch_idx_d] = 1'b1;
    samp_d          = {NCH{1'b0}};
    samp_b_d        = {NCH{1'b1}};
    busy_d          = (state_d == RUN);
    done_d          = (state_d == FINISH);
    if (state_d == RUN) begin
      if (phase_nxt_s == TRACK) begin
        samp_d = one_s;
      end else begin
        samp_d = {NCH{1'b0}};
      end
      if (phase_nxt_s == HOLD) begin
        samp_b_d = {NCH{1'b1}};
      end else begin
        samp_b_d = ~one_s;
      end
    end else begin
      samp_d   = {NCH{1'b0}};
      samp_b_d = {NCH{1'b1}};
    end
  end

  // state, configuration and output registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      period_q    <= {CNT_W{1'b0}};
      width_q     <= {CNT_W{1'b0}};
      gap_q       <= {GAP_W{1'b0}};
      ch_en_q     <= {NCH{1'b0}};
      stop_pend_q <= 1'b0;
      ch_idx_q    <= {CH_W{1'b0}};
      samp_q      <= {NCH{1'b0}};
      samp_b_q    <= {NCH{1'b1}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      width_q     <= width_d;
      gap_q       <= gap_d;
      ch_en_q     <= ch_en_d;
      stop_pend_q <= stop_pend_d;
      ch_idx_q    <= ch_idx_d;
      samp_q      <= samp_d;
      samp_b_q    <= samp_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign samp   = samp_q;
  assign samp_b = samp_b_q;
  assign ch_idx = ch_idx_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_samp_phase_gen.sv
// Self-checking bench for samp_phase_gen (NCH=4, CNT_W=8, GAP_W=2).
// A slot-arithmetic reference model predicts every output each cycle; a
// vector table, directed sequences and random traffic drive the design.
module tb_samp_phase_gen;

  logic       clk_in = 1'b0;
  logic       rst, start, stop, mode;
  logic [7:0] period, width;
  logic [1:0] gap;
  logic [3:0] ch_en;
  logic [3:0] samp, samp_b;
  logic [1:0] ch_idx;
  logic       busy, done;

  samp_phase_gen #(.NCH(4), .CNT_W(8), .GAP_W(2)) dut (
    .clk_in(clk_in), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .period(period), .width(width), .gap(gap), .ch_en(ch_en),
    .samp(samp), .samp_b(samp_b), .ch_idx(ch_idx), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: a run is a list of enabled channels and a cycle count t
  logic m_active = 1'b0;
  logic m_done   = 1'b0;
  logic m_mode;
  int   m_t, m_p, m_w, m_g, m_total;
  int   m_ens[$];

  // per-test accumulators
  int acc_busy, acc_done, acc_samp0, acc_sb0;

  typedef struct {
    logic       start;
    logic [3:0] samp;
    logic [3:0] samp_b;
    logic [1:0] idx;
    logic       busy;
    logic       done;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_active) begin
      if (stop && !m_mode && m_total < 0) m_total = m_t / m_p + 1;
      m_t++;
      if (m_total >= 0 && m_t == m_total * m_p) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start && !stop) begin
      m_mode = mode;
      m_w    = (width == 8'd0) ? 1 : int'(width);
      m_g    = int'(gap);
      m_p    = (int'(period) > m_w + 2 * m_g) ? int'(period) : m_w + 2 * m_g;
      m_ens.delete();
      for (int i = 0; i < 4; i++) if (ch_en[i]) m_ens.push_back(i);
      if (m_ens.size() == 0) begin
        m_done = 1'b1;
      end else begin
        m_active = 1'b1;
        m_t      = 0;
        m_total  = m_mode ? m_ens.size() : -1;
      end
    end
  endtask

  // one clock: advance model, then compare all outputs after the edge
  task automatic cyc();
    logic [3:0] es, esb;
    logic [1:0] ei;
    logic       eb, ed;
    int         c, ch;
    @(posedge clk_in);
    model_edge();
    #1;
    es = 4'b0000; esb = 4'b1111; ei = 2'd0; eb = 1'b0; ed = m_done;
    if (m_active) begin
      c  = m_t % m_p;
      ch = m_ens[(m_t / m_p) % m_ens.size()];
      if (c >= m_g && c < m_g + m_w) es[ch] = 1'b1;
      if (c < 2 * m_g + m_w) esb[ch] = 1'b0;
      ei = 2'(ch);
      eb = 1'b1;
      ed = 1'b0;
    end
    chk("model_samp", 32'(samp), 32'(es));
    chk("model_samp_b", 32'(samp_b), 32'(esb));
    chk("model_ch_idx", 32'(ch_idx), 32'(ei));
    chk("model_busy", 32'(busy), 32'(eb));
    chk("model_done", 32'(done), 32'(ed));
    chk("no_overlap", 32'(samp & samp_b), 32'd0);
    if (busy) acc_busy++;
    if (done) acc_done++;
    if (samp[0]) acc_samp0++;
    if (busy && samp_b[0]) acc_sb0++;
  endtask

  task automatic clr_acc();
    acc_busy = 0; acc_done = 0; acc_samp0 = 0; acc_sb0 = 0;
  endtask

  task automatic cfg(input logic md, input logic [7:0] per, input logic [7:0] wid,
                     input logic [1:0] gp, input logic [3:0] en);
    mode = md; period = per; width = wid; gap = gp; ch_en = en;
  endtask

  task automatic run_table();
    cfg(1'b1, 8'd8, 8'd3, 2'd1, 4'b0101);
    for (int i = 0; i < 18; i++) begin
      start = tbl[i].start;
      cyc();
      chk("tbl_samp", 32'(samp), 32'(tbl[i].samp));
      chk("tbl_samp_b", 32'(samp_b), 32'(tbl[i].samp_b));
      chk("tbl_ch_idx", 32'(ch_idx), 32'(tbl[i].idx));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
      chk("tbl_done", 32'(done), 32'(tbl[i].done));
    end
    start = 1'b0;
  endtask

  initial begin
    logic cmp_b;
    // single-shot ch0+ch2, period 8, width 3, gap 1; row i = inputs, then state after edge
    tbl[0]  = '{1'b1, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0000, 4'b1111, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b1111, 2'd0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b1111, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0100, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b0100, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0100, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'b0000, 4'b1011, 2'd2, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 4'b1111, 2'd2, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 4'b0000, 4'b1111, 2'd0, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg(1'b0, 8'd0, 8'd0, 2'd0, 4'b0000);
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_samp_b", 32'(samp_b), 32'hF);
    chk("reset_busy", 32'(busy), 32'd0);

    // test 1: table-driven single-shot run
    run_table();

    // test 2: clamp, w_eff=1, p_eff=7
    cfg(1'b1, 8'd2, 8'd0, 2'd3, 4'b0001);
    clr_acc();
    start = 1'b1; cyc(); start = 1'b0;
    repeat (9) cyc();
    chk("clamp_track_cycles", 32'(acc_samp0), 32'd1);
    chk("clamp_hold_in_slot", 32'(acc_sb0), 32'd0);
    chk("clamp_busy_cycles", 32'(acc_busy), 32'd7);
    chk("clamp_done_count", 32'(acc_done), 32'd1);

    // test 3: continuous, stop at slot 5 count 2
    cfg(1'b0, 8'd6, 8'd2, 2'd0, 4'b1111);
    clr_acc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 41; i++) begin
      stop = (i == 32);
      if (busy) begin
        cmp_b = samp[ch_idx] ^ samp_b[ch_idx];
        chk("gap0_complement", 32'(cmp_b), 32'd1);
      end
      cyc();
    end
    stop = 1'b0;
    chk("cont_busy_cycles", 32'(acc_busy), 32'd36);
    chk("cont_done_count", 32'(acc_done), 32'd1);

    // test 4: empty mask, then start+stop collision
    cfg(1'b1, 8'd8, 8'd3, 2'd1, 4'b0000);
    start = 1'b1; cyc(); start = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_busy", 32'(busy), 32'd0);
    cyc();
    chk("empty_done_clear", 32'(done), 32'd0);
    cfg(1'b1, 8'd8, 8'd3, 2'd1, 4'b1111);
    clr_acc();
    start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    repeat (4) cyc();
    chk("collide_busy", 32'(acc_busy), 32'd0);
    chk("collide_done", 32'(acc_done), 32'd0);

    // test 5: reset during TRACK, then a clean rerun of test 1
    cfg(1'b1, 8'd8, 8'd3, 2'd1, 4'b0101);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    chk("pre_rst_track", 32'(samp), 32'h1);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_samp", 32'(samp), 32'd0);
    chk("rst_samp_b", 32'(samp_b), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    cyc();
    run_table();

    // test 6: config churn and start pulses while RUN / FINISH
    cfg(1'b1, 8'd8, 8'd3, 2'd1, 4'b0101);
    clr_acc();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      start = (i == 2 || i == 5 || i == 9 || i == 17);
      if (i == 3) cfg(1'b0, 8'd3, 8'd7, 2'd0, 4'b1010);
      cyc();
    end
    start = 1'b0;
    chk("churn_busy_cycles", 32'(acc_busy), 32'd16);
    chk("churn_done_count", 32'(acc_done), 32'd1);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start  = ($urandom_range(0, 19) == 0);
      stop   = ($urandom_range(0, 29) == 0);
      rst    = ($urandom_range(0, 299) == 0);
      mode   = 1'($urandom_range(0, 1));
      period = 8'($urandom_range(0, 12));
      width  = 8'($urandom_range(0, 6));
      gap    = 2'($urandom_range(0, 3));
      ch_en  = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
